// File: rtl/fetch_decode_queue.sv
// Two-wide fetch-to-decode instruction buffer: compacts nonzero fetch slots into a
// circular queue and presents the two oldest entries, in program order, to decode.
module fetch_decode_queue #(
    parameter int DEPTH = 8,
    parameter int XLEN  = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [XLEN-1:0]            in_inst_a,
    input  logic [XLEN-1:0]            in_pc_a,
    input  logic [XLEN-1:0]            in_inst_b,
    input  logic [XLEN-1:0]            in_pc_b,
    output logic                       in_ready,
    output logic                       out_valid_a,
    output logic [XLEN-1:0]            out_inst_a,
    output logic [XLEN-1:0]            out_pc_a,
    output logic                       out_valid_b,
    output logic [XLEN-1:0]            out_inst_b,
    output logic [XLEN-1:0]            out_pc_b,
    input  logic [1:0]                 dec_take,
    output logic [$clog2(DEPTH):0]     occupancy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [XLEN-1:0] r_inst [DEPTH];
    logic [XLEN-1:0] r_pc   [DEPTH];
    logic [PW-1:0]   r_head;
    logic [PW-1:0]   r_tail;
    logic [CW-1:0]   r_count;

    logic [1:0]      w_take;
    logic [1:0]      w_deq;
    logic [1:0]      w_enq;
    logic            w_push;
    logic            w_a_nz;
    logic            w_b_nz;
    logic [PW-1:0]   w_tail_b;
    logic [PW-1:0]   w_head_b;

    always_comb begin
        w_take   = (dec_take == 2'd3) ? 2'd2 : dec_take;
        // take exceeding count only happens when count < 2, so its low bits are exact
        w_deq    = (CW'(w_take) > r_count) ? r_count[1:0] : w_take;
        w_push   = in_valid & in_ready;
        w_a_nz   = |in_inst_a;
        w_b_nz   = |in_inst_b;
        w_enq    = w_push ? ({1'b0, w_a_nz} + {1'b0, w_b_nz}) : 2'd0;
        w_tail_b = w_a_nz ? r_tail + PW'(1) : r_tail;
        w_head_b = r_head + PW'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + PW'(w_deq);
            r_tail  <= r_tail + PW'(w_enq);
            r_count <= r_count + CW'(w_enq) - CW'(w_deq);
        end
    end

    // Storage is intentionally left unreset; valid gating hides stale contents.
    always_ff @(posedge clk) begin
        if (w_push && !flush) begin
            if (w_a_nz) begin
                r_inst[r_tail] <= in_inst_a;
                r_pc[r_tail]   <= in_pc_a;
            end
            if (w_b_nz) begin
                r_inst[w_tail_b] <= in_inst_b;
                r_pc[w_tail_b]   <= in_pc_b;
            end
        end
    end

    always_comb begin
        in_ready    = (r_count <= CW'(DEPTH - 2));
        occupancy   = r_count;
        out_valid_a = (r_count >= CW'(1));
        out_valid_b = (r_count >= CW'(2));
        out_inst_a  = out_valid_a ? r_inst[r_head]   : '0;
        out_pc_a    = out_valid_a ? r_pc[r_head]     : '0;
        out_inst_b  = out_valid_b ? r_inst[w_head_b] : '0;
        out_pc_b    = out_valid_b ? r_pc[w_head_b]   : '0;
    end

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Bench for fetch_decode_queue: directed scenarios plus random traffic, all checked
// against a queue-based reference model of the buffer.
module tb_fetch_decode_queue;

    localparam int DEPTH = 8;
    localparam int XLEN  = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic            flush;
    logic            in_valid;
    logic [XLEN-1:0] in_inst_a, in_pc_a, in_inst_b, in_pc_b;
    logic            in_ready;
    logic            out_valid_a, out_valid_b;
    logic [XLEN-1:0] out_inst_a, out_pc_a, out_inst_b, out_pc_b;
    logic [1:0]      dec_take;
    logic [$clog2(DEPTH):0] occupancy;

    int n_vec = 0;
    int n_err = 0;

    bit [63:0] mq[$];

    fetch_decode_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid),
        .in_inst_a(in_inst_a), .in_pc_a(in_pc_a),
        .in_inst_b(in_inst_b), .in_pc_b(in_pc_b),
        .in_ready(in_ready),
        .out_valid_a(out_valid_a), .out_inst_a(out_inst_a), .out_pc_a(out_pc_a),
        .out_valid_b(out_valid_b), .out_inst_b(out_inst_b), .out_pc_b(out_pc_b),
        .dec_take(dec_take), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        bit [63:0] ea, eb;
        int sz;
        sz = mq.size();
        ea = (sz >= 1) ? mq[0] : 64'd0;
        eb = (sz >= 2) ? mq[1] : 64'd0;
        chk("in_ready",   in_ready,    sz <= DEPTH - 2);
        chk("occupancy",  occupancy,   sz);
        chk("valid_a",    out_valid_a, sz >= 1);
        chk("valid_b",    out_valid_b, sz >= 2);
        chk("entry_a",    {out_pc_a, out_inst_a}, ea);
        chk("entry_b",    {out_pc_b, out_inst_b}, eb);
    endtask

    // Model next state from pre-edge contents, apply one clock, then compare.
    task automatic cyc(input logic v, input logic [31:0] ia, input logic [31:0] pa,
                       input logic [31:0] ib, input logic [31:0] pb,
                       input logic [1:0] tk, input logic fl);
        int t, n;
        bit rdy;
        in_valid = v; in_inst_a = ia; in_pc_a = pa;
        in_inst_b = ib; in_pc_b = pb; dec_take = tk; flush = fl;
        @(posedge clk);
        rdy = (mq.size() <= DEPTH - 2);
        if (fl) begin
            mq.delete();
        end else begin
            t = (tk == 2'd3) ? 2 : int'(tk);
            n = (t < mq.size()) ? t : mq.size();
            for (int i = 0; i < n; i++) void'(mq.pop_front());
            if (v && rdy) begin
                if (ia != 0) mq.push_back({pa, ia});
                if (ib != 0) mq.push_back({pb, ib});
            end
        end
        #1;
        check_all();
    endtask

    initial begin
        logic [31:0] prev_pc, old_b, ia, ib, pc;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; dec_take = 2'd0;
        in_inst_a = '0; in_pc_a = '0; in_inst_b = '0; in_pc_b = '0;
        #12;
        check_all();
        chk("rst_ready", in_ready, 1'b1);
        @(negedge clk);
        reset = 1'b0;

        // First pair becomes visible right after the write edge
        cyc(1, 32'h00500093, 32'd0, 32'h00a00113, 32'd4, 2'd0, 0);
        chk("t1_occ", occupancy, 2);
        chk("t1_pc_b", out_pc_b, 4);

        // Fill to DEPTH, fifth pair dropped, then drain two
        for (int i = 1; i <= 3; i++)
            cyc(1, 32'h13 + i, 32'(8 * i), 32'h33 + i, 32'(8 * i + 4), 2'd0, 0);
        chk("t2_full_occ", occupancy, 8);
        chk("t2_full_rdy", in_ready, 1'b0);
        cyc(1, 32'h77, 32'h40, 32'h99, 32'h44, 2'd0, 0);
        chk("t2_drop_occ", occupancy, 8);
        cyc(0, 0, 0, 0, 0, 2'd2, 0);
        chk("t2_take_occ", occupancy, 6);
        chk("t2_take_rdy", in_ready, 1'b1);

        // Bubble slots
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 2'd3, 0);
        cyc(1, 32'd0, 32'd8, 32'h00208233, 32'd12, 2'd0, 0);
        chk("t3_occ", occupancy, 1);
        chk("t3_pc_a", out_pc_a, 12);
        cyc(1, 32'd0, 32'd16, 32'd0, 32'd20, 2'd0, 0);
        chk("t3_zero_occ", occupancy, 1);

        // Steady state at occupancy 6 across pointer wrap
        cyc(1, 32'h55, 0, 32'h66, 0, 2'd0, 1);
        pc = 32'h100;
        for (int i = 0; i < 3; i++) begin
            cyc(1, pc | 1, pc, (pc + 4) | 1, pc + 4, 2'd0, 0);
            pc += 8;
        end
        prev_pc = out_pc_a;
        for (int i = 0; i < 10; i++) begin
            cyc(1, pc | 1, pc, (pc + 4) | 1, pc + 4, 2'd2, 0);
            pc += 8;
            chk("t4_occ", occupancy, 6);
            chk("t4_step", out_pc_a, prev_pc + 8);
            prev_pc = out_pc_a;
        end

        // Partial dequeue shifts b onto a; over-take from one entry clamps
        cyc(0, 0, 0, 0, 0, 2'd2, 0);
        cyc(0, 0, 0, 0, 0, 2'd1, 0);
        chk("t5_occ3", occupancy, 3);
        old_b = out_pc_b;
        cyc(0, 0, 0, 0, 0, 2'd1, 0);
        chk("t5_shift", out_pc_a, old_b);
        cyc(0, 0, 0, 0, 0, 2'd2, 0);
        cyc(1, 32'd0, 32'h200, 32'h1234, 32'h204, 2'd0, 0);
        cyc(0, 0, 0, 0, 0, 2'd2, 0);
        chk("t5_empty_occ", occupancy, 0);

        // Flush beats enqueue and dequeue
        cyc(1, 32'h11, 32'h300, 32'h22, 32'h304, 2'd0, 0);
        cyc(1, 32'h33, 32'h308, 32'h44, 32'h30c, 2'd0, 0);
        cyc(1, 32'h55, 32'h310, 32'h00, 32'h314, 2'd0, 0);
        chk("t6_occ5", occupancy, 5);
        cyc(1, 32'h66, 32'h318, 32'h77, 32'h31c, 2'd2, 1);
        chk("t6_flush_occ", occupancy, 0);

        // Asynchronous reset between edges
        cyc(1, 32'h88, 32'h400, 32'h99, 32'h404, 2'd0, 0);
        #2 reset = 1'b1;
        #1;
        chk("rst_async_va", out_valid_a, 1'b0);
        chk("rst_async_occ", occupancy, 0);
        mq.delete();
        @(negedge clk);
        reset = 1'b0;
        check_all();

        // Random traffic
        pc = 32'h1000;
        for (int i = 0; i < 3000; i++) begin
            ia = ($urandom_range(3) == 0) ? 32'd0 : ($urandom | 32'h1);
            ib = ($urandom_range(3) == 0) ? 32'd0 : ($urandom | 32'h1);
            cyc(($urandom_range(9) < 8), ia, pc, ib, pc + 4,
                2'($urandom_range(3)), ($urandom_range(39) == 0));
            pc += 8;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
